// File: rtl/bool_arbiter.sv
// bool_arbiter: round-robin sharing of one 32-bit boolean unit between two requesters, one-entry result buffer.
// Define BOOL_ARB_OPCHECK_EN to flag unsupported opcodes on res_err (otherwise res_err is tied low).
module bool_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_id,
    output logic        res_err,
    output logic [15:0] done_cnt0,
    output logic [15:0] done_cnt1
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t      state;
    logic        last_grant, grant, can_accept, fire;
    logic [3:0]  op;
    logic [31:0] a, b, result;

    assign can_accept = state == EMPTY || res_ready;
    // With both valid, the requester that did not win last time gets the unit
    assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign fire       = req0_ready || req1_ready;
    assign op         = grant ? req1_op : req0_op;
    assign a          = grant ? req1_a : req0_a;
    assign b          = grant ? req1_b : req0_b;
    assign res_valid  = state == FULL;

    always_comb begin
        result = '0;
        case (op)
            4'b1010: result = a;
            4'b1000: result = a & b;
            4'b0001: result = ~(a | b);
            4'b1110: result = a | b;
            4'b1001: result = ~(a ^ b);
            4'b0110: result = a ^ b;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            res_data   <= '0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            if (fire) begin
                state      <= FULL;
                res_data   <= result;
                res_id     <= grant;
                last_grant <= grant;
            end else if (res_ready) begin
                state <= EMPTY;
            end
            if (res_valid && res_ready && !res_id && done_cnt0 != 16'hFFFF)
                done_cnt0 <= done_cnt0 + 16'd1;
            if (res_valid && res_ready && res_id && done_cnt1 != 16'hFFFF)
                done_cnt1 <= done_cnt1 + 16'd1;
        end
    end

`ifdef BOOL_ARB_OPCHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            res_err <= 1'b0;
        else if (fire)
            res_err <= !(op inside {4'b1010, 4'b1000, 4'b0001, 4'b1110, 4'b1001, 4'b0110});
    end
`else
    assign res_err = 1'b0;
`endif
endmodule

// File: tb/tb_bool_arbiter.sv
// tb_bool_arbiter: directed, table-driven self-checking bench for bool_arbiter.
module tb_bool_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready, res_id, res_err;
    logic [31:0] res_data;
    logic [15:0] done_cnt0, done_cnt1;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] exp;
        logic        ok;
    } vec_t;
    vec_t vt[16];

    bool_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_err(res_err),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for ready, then drop valid just after the accepting edge
    task automatic send(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: id %0d ready 0 expected 1", id);
        end
        step();
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    initial begin
        vt[0]  = '{4'b0000, 32'h0000_0000, 1'b0};
        vt[1]  = '{4'b0001, 32'hE0C0_A080, 1'b1};
        vt[2]  = '{4'b0010, 32'h0000_0000, 1'b0};
        vt[3]  = '{4'b0011, 32'h0000_0000, 1'b0};
        vt[4]  = '{4'b0100, 32'h0000_0000, 1'b0};
        vt[5]  = '{4'b0101, 32'h0000_0000, 1'b0};
        vt[6]  = '{4'b0110, 32'h1D3B_5977, 1'b1};
        vt[7]  = '{4'b0111, 32'h0000_0000, 1'b0};
        vt[8]  = '{4'b1000, 32'h0204_0608, 1'b1};
        vt[9]  = '{4'b1001, 32'hE2C4_A688, 1'b1};
        vt[10] = '{4'b1010, 32'h1234_5678, 1'b1};
        vt[11] = '{4'b1011, 32'h0000_0000, 1'b0};
        vt[12] = '{4'b1100, 32'h0000_0000, 1'b0};
        vt[13] = '{4'b1101, 32'h0000_0000, 1'b0};
        vt[14] = '{4'b1110, 32'h1F3F_5F7F, 1'b1};
        vt[15] = '{4'b1111, 32'h0000_0000, 1'b0};

        reset_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_cnt0", 32'(done_cnt0), 32'd0);
        chk("rst_cnt1", 32'(done_cnt1), 32'd0);
        reset_n = 1'b1;
        step();

        // Contention from reset: grants alternate 0,1,0,1
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0110; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_op = 4'b0001; req1_a = '0; req1_b = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_rdy0", k), 32'(req0_ready), 32'(k % 2 == 0));
            chk($sformatf("rr%0d_rdy1", k), 32'(req1_ready), 32'(k % 2 == 1));
            step();
            chk($sformatf("rr%0d_id", k), 32'(res_id), 32'(k % 2));
            chk($sformatf("rr%0d_data", k), res_data, (k % 2 == 1) ? 32'hFFFF_FFFF : 32'h0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("rr_cnt0", 32'(done_cnt0), 32'd2);
        chk("rr_cnt1", 32'(done_cnt1), 32'd2);
        chk("rr_empty", 32'(res_valid), 32'd0);

        // Single request, one-cycle latency
        send(1'b0, 4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_data", res_data, 32'hF000_F000);
        chk("t1_id", 32'(res_id), 32'd0);
        step();
        chk("t1_cnt0", 32'(done_cnt0), 32'd3);

        // Stall while FULL, then same-cycle handoff
        send(1'b0, 4'b1010, 32'hAAAA_5555, 32'h0);
        res_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'b1110; req1_a = 32'h0; req1_b = 32'h0000_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_rdy1", k), 32'(req1_ready), 32'd0);
            chk($sformatf("stall%0d_valid", k), 32'(res_valid), 32'd1);
            chk($sformatf("stall%0d_data", k), res_data, 32'hAAAA_5555);
            chk($sformatf("stall%0d_id", k), 32'(res_id), 32'd0);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("handoff_rdy1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        chk("handoff_valid", 32'(res_valid), 32'd1);
        chk("handoff_data", res_data, 32'h0000_FFFF);
        chk("handoff_id", 32'(res_id), 32'd1);
        chk("handoff_cnt0", 32'(done_cnt0), 32'd4);
        step();
        chk("handoff_cnt1", 32'(done_cnt1), 32'd3);

        // Opcode sweep, alternating requesters
        for (int i = 0; i < 16; i++) begin
            send(1'(i % 2), vt[i].op, 32'h1234_5678, 32'h0F0F_0F0F);
            chk($sformatf("op%0d_valid", i), 32'(res_valid), 32'd1);
            chk($sformatf("op%0d_data", i), res_data, vt[i].exp);
            chk($sformatf("op%0d_id", i), 32'(res_id), 32'(i % 2));
`ifdef BOOL_ARB_OPCHECK_EN
            chk($sformatf("op%0d_err", i), 32'(res_err), 32'(!vt[i].ok));
`else
            chk($sformatf("op%0d_err", i), 32'(res_err), 32'd0);
`endif
        end
        step();
        chk("sweep_cnt0", 32'(done_cnt0), 32'd12);
        chk("sweep_cnt1", 32'(done_cnt1), 32'd11);

        // Saturation of done_cnt1
        force dut.done_cnt1 = 16'hFFFE;
        #1;
        release dut.done_cnt1;
        for (int k = 0; k < 3; k++) begin
            send(1'b1, 4'b1010, 32'(k), 32'h0);
            step();
            chk($sformatf("sat%0d_cnt1", k), 32'(done_cnt1), 32'h0000_FFFF);
        end

        // Asynchronous reset while FULL and stalled
        res_ready = 1'b0;
        send(1'b0, 4'b1010, 32'hDEAD_BEEF, 32'h0);
        chk("pre_arst_valid", 32'(res_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_data", res_data, 32'd0);
        chk("arst_cnt0", 32'(done_cnt0), 32'd0);
        chk("arst_cnt1", 32'(done_cnt1), 32'd0);
        step();
        reset_n = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b1010; req0_a = 32'h1111_1111;
        req1_valid = 1'b1; req1_op = 4'b1010; req1_a = 32'h2222_2222;
        @(negedge clk);
        chk("post_rst_rdy0", 32'(req0_ready), 32'd1);
        chk("post_rst_rdy1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("post_rst_id", 32'(res_id), 32'd0);
        chk("post_rst_data", res_data, 32'h1111_1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
